// File: rtl/rx_ltssm_pkg.sv
// Shared LTSSM receive-side constants: ordered-set IDs, mode codes, FSM states.
package rx_ltssm_pkg;

  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;

  // Symbol positions inside a 16-symbol training ordered set
  localparam int LINK_SYM = 1;
  localparam int RATE_SYM = 4;
  localparam int ID_SYM   = 6;

  typedef enum logic [1:0] {
    MODE_TS1_ANY  = 2'd0,
    MODE_TS1_LINK = 2'd1,
    MODE_TS2_ANY  = 2'd2,
    MODE_TS2_LINK = 2'd3
  } os_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } qual_state_e;

  // Pull symbol k out of a 128-bit ordered set
  function automatic logic [7:0] os_sym(input logic [127:0] os, input int k);
    return os[k*8 +: 8];
  endfunction

endpackage

// File: rtl/rx_os_lane_checker.sv
// One lane: ordered-set match decode, consecutive-match counter, qualified flag.
module rx_os_lane_checker
  import rx_ltssm_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_cnt_en,
  input  logic             i_active,
  input  logic             i_os_valid,
  input  logic [127:0]     i_os_data,
  input  logic [1:0]       i_mode,
  input  logic [7:0]       i_link,
  input  logic [CNT_W-1:0] i_req,
  output logic             o_match,
  output logic             o_qual_nxt,
  output logic             o_qual
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_qual;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       w_id;
  logic [7:0]       w_lnk;
  logic             w_want_link;
  logic             w_hit;
  logic             w_unused_sym;

  assign w_id        = i_os_data[ID_SYM*8 +: 8];
  assign w_lnk       = i_os_data[LINK_SYM*8 +: 8];
  assign w_want_link = (i_mode == MODE_TS1_LINK) || (i_mode == MODE_TS2_LINK);
  // Symbols this lane never inspects
  assign w_unused_sym = ^{i_os_data[127:56], i_os_data[47:16], i_os_data[7:0]};

  assign o_match = (w_id == (i_mode[1] ? TS2_ID : TS1_ID)) && (!w_want_link || (w_lnk == i_link));
  assign w_hit   = i_cnt_en && i_active && i_os_valid;

  // Next counter: saturate at the required count, any non-matching OS restarts the run
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr)
      w_cnt_nxt = '0;
    else if (w_hit)
      w_cnt_nxt = !o_match ? '0 : (r_cnt >= i_req) ? r_cnt : r_cnt + 1'b1;
  end

  // Flag follows the counter; exported early so the top can finish in the qualifying cycle
  assign o_qual_nxt = i_clr ? 1'b0 : (w_hit ? (w_cnt_nxt == i_req) : r_qual);
  assign o_qual     = r_qual;

  // Counter and qualified flag registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_qual <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_qual <= o_qual_nxt;
    end
  end

endmodule

// File: rtl/rx_os_lane_qualifier.sv
// Multi-lane training-set qualifier: FSM, timeout timer, lane reduction and OS field capture.
module rx_os_lane_qualifier
  import rx_ltssm_pkg::*;
#(
  parameter int NUM_LANES = 16,
  parameter int CNT_W     = 5,
  parameter int TMR_W     = 24,
  parameter int ALL_LANES = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [1:0]               i_mode,
  input  logic [CNT_W-1:0]         i_req_count,
  input  logic [TMR_W-1:0]         i_timeout_cycles,
  input  logic [NUM_LANES-1:0]     i_lane_mask,
  input  logic [7:0]               i_link_number,
  input  logic [NUM_LANES*128-1:0] i_os_data,
  input  logic [NUM_LANES-1:0]     i_os_valid,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_success,
  output logic                     o_timed_out,
  output logic [NUM_LANES-1:0]     o_qualified_mask,
  output logic [7:0]               o_rate_id,
  output logic [7:0]               o_link_number_out,
  output logic                     o_upconfig_cap
);

  qual_state_e            r_state;
  logic                   r_busy, r_done, r_success, r_timed_out;
  logic [1:0]             r_mode;
  logic [CNT_W-1:0]       r_req;
  logic [NUM_LANES-1:0]   r_mask;
  logic [7:0]             r_link;
  logic [TMR_W-1:0]       r_tmr;
  logic [7:0]             r_rate_id, r_link_out;
  logic                   r_upcfg;

  logic [NUM_LANES-1:0][127:0] w_lane_data;
  logic [NUM_LANES-1:0]   w_match, w_qual_nxt, w_qual, w_cap_hit;
  logic                   w_cnt_en, w_clr, w_all_q, w_any_q, w_qualify, w_timeout;
  logic                   w_cap_vld;
  logic [7:0]             w_cap_rate, w_cap_link;

  assign w_lane_data = i_os_data;
  // Lanes only count in plain RUN cycles; a start or abort cycle wipes them instead
  assign w_cnt_en = (r_state == ST_RUN) && !i_start && !i_abort;
  assign w_clr    = i_start || i_abort;

  genvar g;
  for (g = 0; g < NUM_LANES; g++) begin : g_lane
    rx_os_lane_checker #(.CNT_W(CNT_W)) u_chk (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_clr      (w_clr),
      .i_cnt_en   (w_cnt_en),
      .i_active   (r_mask[g]),
      .i_os_valid (i_os_valid[g]),
      .i_os_data  (w_lane_data[g]),
      .i_mode     (r_mode),
      .i_link     (r_link),
      .i_req      (r_req),
      .o_match    (w_match[g]),
      .o_qual_nxt (w_qual_nxt[g]),
      .o_qual     (w_qual[g])
    );
  end

  // Empty mask qualifies immediately in both reduction modes
  assign w_all_q   = &(w_qual_nxt | ~r_mask);
  assign w_any_q   = (|(w_qual_nxt & r_mask)) || (r_mask == '0);
  assign w_qualify = (ALL_LANES != 0) ? w_all_q : w_any_q;
  assign w_timeout = (r_tmr == TMR_W'(1));

  assign w_cap_hit = {NUM_LANES{w_cnt_en}} & r_mask & i_os_valid & w_match;

  // Pick the lowest-index active lane carrying a matching OS this cycle
  always_comb begin
    w_cap_vld  = 1'b0;
    w_cap_rate = '0;
    w_cap_link = '0;
    for (int l = NUM_LANES - 1; l >= 0; l--) begin
      if (w_cap_hit[l]) begin
        w_cap_vld  = 1'b1;
        w_cap_rate = os_sym(w_lane_data[l], RATE_SYM);
        w_cap_link = os_sym(w_lane_data[l], LINK_SYM);
      end
    end
  end

  // Control FSM with timer and held results; abort beats start
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_success   <= 1'b0;
      r_timed_out <= 1'b0;
      r_mode      <= '0;
      r_req       <= '0;
      r_mask      <= '0;
      r_link      <= '0;
      r_tmr       <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        r_state     <= ST_IDLE;
        r_busy      <= 1'b0;
        r_success   <= 1'b0;
        r_timed_out <= 1'b0;
      end else if (i_start) begin
        r_state     <= ST_RUN;
        r_busy      <= 1'b1;
        r_success   <= 1'b0;
        r_timed_out <= 1'b0;
        r_mode      <= i_mode;
        r_req       <= (i_req_count == '0) ? CNT_W'(1) : i_req_count;
        r_mask      <= i_lane_mask;
        r_link      <= i_link_number;
        r_tmr       <= i_timeout_cycles;
      end else begin
        case (r_state)
          ST_RUN: begin
            if (r_tmr != '0) r_tmr <= r_tmr - 1'b1;
            if (w_qualify || w_timeout) begin
              r_state     <= ST_DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_success   <= w_qualify;
              r_timed_out <= !w_qualify;
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Captured OS fields; only matching OS seen while running update them
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rate_id  <= '0;
      r_link_out <= '0;
      r_upcfg    <= 1'b0;
    end else if (w_cap_vld) begin
      r_rate_id  <= w_cap_rate;
      r_link_out <= w_cap_link;
      r_upcfg    <= w_cap_rate[6];
    end
  end

  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_success         = r_success;
  assign o_timed_out       = r_timed_out;
  assign o_qualified_mask  = w_qual;
  assign o_rate_id         = r_rate_id;
  assign o_link_number_out = r_link_out;
  assign o_upconfig_cap    = r_upcfg;

endmodule

// File: tb/tb_rx_os_lane_qualifier.sv
// Bench: two instances (all-lanes / any-lane) against a transaction-level reference model.
module tb_rx_os_lane_qualifier;
  localparam int NL = 4;
  localparam int CW = 5;
  localparam int TW = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start, abort;
  logic [1:0]      mode;
  logic [CW-1:0]   req;
  logic [TW-1:0]   tmo;
  logic [NL-1:0]   mask;
  logic [7:0]      lnk;
  logic [NL*128-1:0] osd;
  logic [NL-1:0]   osv;

  logic          busy[2], done[2], succ[2], tmd[2], upc[2];
  logic [NL-1:0] qm[2];
  logic [7:0]    rate[2], lout[2];

  int n_tests = 0;
  int n_fail  = 0;

  rx_os_lane_qualifier #(.NUM_LANES(NL), .CNT_W(CW), .TMR_W(TW), .ALL_LANES(1)) u_dut_all (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_mode(mode),
    .i_req_count(req), .i_timeout_cycles(tmo), .i_lane_mask(mask), .i_link_number(lnk),
    .i_os_data(osd), .i_os_valid(osv), .o_busy(busy[0]), .o_done(done[0]),
    .o_success(succ[0]), .o_timed_out(tmd[0]), .o_qualified_mask(qm[0]),
    .o_rate_id(rate[0]), .o_link_number_out(lout[0]), .o_upconfig_cap(upc[0]));

  rx_os_lane_qualifier #(.NUM_LANES(NL), .CNT_W(CW), .TMR_W(TW), .ALL_LANES(0)) u_dut_any (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_mode(mode),
    .i_req_count(req), .i_timeout_cycles(tmo), .i_lane_mask(mask), .i_link_number(lnk),
    .i_os_data(osd), .i_os_valid(osv), .o_busy(busy[1]), .o_done(done[1]),
    .o_success(succ[1]), .o_timed_out(tmd[1]), .o_qualified_mask(qm[1]),
    .o_rate_id(rate[1]), .o_link_number_out(lout[1]), .o_upconfig_cap(upc[1]));

  // Reference model state: phase 0 idle, 1 running, 2 reporting
  int            m_ph[2];
  int            m_cnt[2][NL];
  bit            m_q[2][NL];
  int            m_tmr[2];
  bit            m_done[2], m_succ[2], m_to[2], m_upc[2];
  logic [7:0]    m_rate[2], m_lnk[2];
  int            mm_mode[2], mm_req[2], mm_link[2];
  logic [NL-1:0] mm_mask[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] sym(input int l, input int k);
    logic [127:0] v;
    v = osd[l*128 +: 128];
    return v[k*8 +: 8];
  endfunction

  function automatic bit os_ok(input int d, input int l);
    logic [7:0] want;
    want = (mm_mode[d] >= 2) ? 8'h45 : 8'h4A;
    return (sym(l, 6) == want) && ((mm_mode[d] % 2 == 0) || (int'(sym(l, 1)) == mm_link[d]));
  endfunction

  task automatic mdl_reset(input int d);
    m_ph[d] = 0; m_tmr[d] = 0; m_done[d] = 0; m_succ[d] = 0; m_to[d] = 0;
    m_upc[d] = 0; m_rate[d] = 0; m_lnk[d] = 0;
    mm_mode[d] = 0; mm_req[d] = 0; mm_link[d] = 0; mm_mask[d] = '0;
    for (int l = 0; l < NL; l++) begin m_cnt[d][l] = 0; m_q[d][l] = 0; end
  endtask

  // One clock of the reference, from the inputs presented before the edge
  task automatic mdl_step(input int d);
    bit capd, q, t;
    int nq, na;
    m_done[d] = 0;
    if (abort) begin
      m_ph[d] = 0; m_succ[d] = 0; m_to[d] = 0;
      for (int l = 0; l < NL; l++) begin m_cnt[d][l] = 0; m_q[d][l] = 0; end
    end else if (start) begin
      m_ph[d] = 1; m_succ[d] = 0; m_to[d] = 0;
      mm_mode[d] = int'(mode); mm_req[d] = (req == 0) ? 1 : int'(req);
      mm_mask[d] = mask; mm_link[d] = int'(lnk); m_tmr[d] = int'(tmo);
      for (int l = 0; l < NL; l++) begin m_cnt[d][l] = 0; m_q[d][l] = 0; end
    end else if (m_ph[d] == 1) begin
      capd = 0; nq = 0; na = 0;
      for (int l = 0; l < NL; l++) begin
        if (mm_mask[d][l]) begin
          na++;
          if (osv[l]) begin
            if (os_ok(d, l)) begin
              m_cnt[d][l] = (m_cnt[d][l] + 1 > mm_req[d]) ? mm_req[d] : m_cnt[d][l] + 1;
              if (!capd) begin
                m_rate[d] = sym(l, 4); m_lnk[d] = sym(l, 1);
                m_upc[d] = (sym(l, 4) >> 6) & 1; capd = 1;
              end
            end else m_cnt[d][l] = 0;
            m_q[d][l] = (m_cnt[d][l] >= mm_req[d]);
          end
          if (m_q[d][l]) nq++;
        end
      end
      q = (na == 0) || ((d == 0) ? (nq == na) : (nq > 0));
      t = (m_tmr[d] == 1);
      if (m_tmr[d] > 0) m_tmr[d]--;
      if (q || t) begin m_ph[d] = 2; m_done[d] = 1; m_succ[d] = q; m_to[d] = !q; end
    end else if (m_ph[d] == 2) m_ph[d] = 0;
  endtask

  function automatic logic [63:0] exp_vec(input int d);
    logic [NL-1:0] q;
    for (int l = 0; l < NL; l++) q[l] = m_q[d][l];
    return {39'd0, (m_ph[d] == 1), m_done[d], m_succ[d], m_to[d], q, m_rate[d], m_lnk[d], m_upc[d]};
  endfunction

  function automatic logic [63:0] got_vec(input int d);
    return {39'd0, busy[d], done[d], succ[d], tmd[d], qm[d], rate[d], lout[d], upc[d]};
  endfunction

  task automatic cmp_all();
    chk("cyc_all", got_vec(0), exp_vec(0));
    chk("cyc_any", got_vec(1), exp_vec(1));
  endtask

  task automatic tick();
    for (int d = 0; d < 2; d++) if (!rst_n) mdl_reset(d); else mdl_step(d);
    @(posedge clk); #1;
    cmp_all();
  endtask

  function automatic logic [127:0] mk_os(input logic [7:0] id, input logic [7:0] lk, input logic [7:0] rt);
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    v[8 +: 8]  = lk;
    v[32 +: 8] = rt;
    v[48 +: 8] = id;
    return v;
  endfunction

  task automatic send(input logic [NL-1:0] lanes, input logic [7:0] id, input logic [7:0] lk, input logic [7:0] rt);
    for (int l = 0; l < NL; l++) osd[l*128 +: 128] = mk_os(id, lk, rt);
    osv = lanes;
    tick();
    osv = '0;
  endtask

  task automatic do_start(input int m, input int r, input int t, input logic [NL-1:0] k, input int l);
    mode = 2'(m); req = CW'(r); tmo = TW'(t); mask = k; lnk = 8'(l);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic rand_cfg();
    mode = 2'($urandom);
    req  = CW'($urandom_range(0, 6));
    tmo  = TW'($urandom_range(0, 40));
    mask = NL'($urandom);
    lnk  = 8'($urandom_range(0, 3));
  endtask

  function automatic logic [127:0] rnd_os();
    int s;
    logic [7:0] id;
    s = $urandom_range(0, 9);
    id = (s < 4) ? 8'h4A : (s < 8) ? 8'h45 : 8'($urandom);
    return mk_os(id, 8'($urandom_range(0, 3)), 8'($urandom));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    start = 0; abort = 0; mode = 0; req = 0; tmo = 0; mask = 0; lnk = 0; osd = '0; osv = '0;
    tick(); tick();
    chk("rst_busy", {63'd0, busy[0]}, 64'd0);
    rst_n = 1'b1;
    tick();

    // All four lanes send 8 TS1 -> success on both reductions
    do_start(0, 8, 0, 4'hF, 0);
    for (int i = 0; i < 8; i++) send(4'hF, 8'h4A, 8'h01, 8'h10);
    chk("r43_done", {63'd0, done[0]}, 64'd1);
    chk("r43_succ", {63'd0, succ[0]}, 64'd1);
    chk("r43_qm",   {60'd0, qm[0]},   64'hF);
    chk("r43_to",   {63'd0, tmd[0]},  64'd0);

    // Link-match TS2 with a mismatched OS in the middle restarts the run
    do_start(3, 8, 0, 4'h4, 5);
    for (int i = 0; i < 4; i++) send(4'h4, 8'h45, 8'h05, 8'h02);
    send(4'h4, 8'h45, 8'h07, 8'h02);
    for (int i = 0; i < 7; i++) send(4'h4, 8'h45, 8'h05, 8'h02);
    chk("r44_not_yet", {60'd0, qm[0]}, 64'h0);
    send(4'h4, 8'h45, 8'h05, 8'h02);
    chk("r44_qm",   {60'd0, qm[0]},   64'h4);
    chk("r44_done", {63'd0, done[0]}, 64'd1);
    tick();

    // Timeout 100 with no traffic: done on cycle 101 after the start cycle
    do_start(0, 8, 100, 4'hF, 0);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (done[0]) begin n = i + 1; break; end
    end
    chk("r45_cycle", 64'(n), 64'd101);
    chk("r45_to",   {63'd0, tmd[0]},  64'd1);
    chk("r45_succ", {63'd0, succ[0]}, 64'd0);
    tick();

    // 8th OS arrives in the cycle the timer runs out: qualification wins
    do_start(0, 8, 10, 4'h1, 0);
    tick(); tick();
    for (int i = 0; i < 8; i++) send(4'h1, 8'h4A, 8'h00, 8'h33);
    chk("r46_succ", {63'd0, succ[0]}, 64'd1);
    chk("r46_to",   {63'd0, tmd[0]},  64'd0);
    tick();

    // Asynchronous reset mid-run clears everything without waiting for a clock
    do_start(0, 8, 0, 4'hF, 0);
    for (int i = 0; i < 5; i++) send(4'hF, 8'h4A, 8'h09, 8'h7F);
    #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) mdl_reset(d);
    cmp_all();
    chk("r47_busy", {63'd0, busy[0]}, 64'd0);
    chk("r47_rate", {56'd0, rate[0]}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_start(0, 8, 0, 4'hF, 0);
    for (int i = 0; i < 8; i++) send(4'hF, 8'h4A, 8'h01, 8'h11);
    chk("r47_succ", {63'd0, succ[0]}, 64'd1);
    tick();

    // Any-lane reduction: lane 1 alone qualifies and supplies the captured fields
    do_start(0, 8, 0, 4'h3, 0);
    for (int i = 0; i < 8; i++) send(4'h2, 8'h4A, 8'h03, 8'h42);
    chk("r48_succ", {63'd0, succ[1]}, 64'd1);
    chk("r48_rate", {56'd0, rate[1]}, 64'h42);
    chk("r48_upc",  {63'd0, upc[1]},  64'd1);
    chk("r48_qm",   {60'd0, qm[1]},   64'h2);
    chk("r48_all_busy", {63'd0, busy[0]}, 64'd1);
    abort = 1'b1; tick(); abort = 1'b0;

    // Randomized runs with occasional restarts and aborts
    for (int tr = 0; tr < 40; tr++) begin
      rand_cfg();
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 0; c < 50; c++) begin
        rand_cfg();
        for (int l = 0; l < NL; l++) osd[l*128 +: 128] = rnd_os();
        osv   = NL'($urandom);
        start = ($urandom_range(0, 39) == 0);
        abort = ($urandom_range(0, 59) == 0);
        tick();
      end
      start = 1'b0; osv = '0;
      abort = 1'b1; tick(); abort = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_os_lane_qualifier.md
RX_OS_LANE_QUALIFIER -- requirements
Module: rx_os_lane_qualifier

Interface
REQ-001 Parameter NUM_LANES, default 16: number of lanes, legal 1..16.
REQ-002 Parameter CNT_W, default 5: width of per-lane consecutive-OS counter and req_count.
REQ-003 Parameter TMR_W, default 24: width of timeout counter.
REQ-004 Parameter ALL_LANES, default 1: 1 = every active lane must qualify; 0 = any one active lane suffices.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse; latches mode, req_count, timeout_cycles, lane_mask, link_number and begins qualification.
REQ-008 abort  in  1  return to IDLE without reporting done.
REQ-009 mode  in  2  0=TS1 any link, 1=TS1 link match, 2=TS2 any link, 3=TS2 link match.
REQ-010 req_count  in  CNT_W  consecutive matching OS required per lane; 0 treated as 1.
REQ-011 timeout_cycles  in  TMR_W  cycles before timeout; 0 disables timeout.
REQ-012 lane_mask  in  NUM_LANES  active lanes.
REQ-013 link_number  in  8  expected link number for modes 1/3.
REQ-014 os_data  in  NUM_LANES*128  per-lane 16-symbol OS, lane i at bits [i*128+127:i*128], symbol k at bits [k*8+7:k*8].
REQ-015 os_valid  in  NUM_LANES  per-lane strobe, os_data lane i valid when bit i high.
REQ-016 busy  out  1  high in RUN.
REQ-017 done  out  1  one-cycle pulse on completion.
REQ-018 success  out  1  held result: qualified before timeout.
REQ-019 timed_out  out  1  held result: timeout occurred.
REQ-020 qualified_mask  out  NUM_LANES  per-lane qualified flags.
REQ-021 rate_id  out  8  symbol 4 of last matching OS on lowest active lane.
REQ-022 link_number_out  out  8  symbol 1 of same OS.
REQ-023 upconfig_cap  out  1  bit 6 of captured symbol 4.

Function
REQ-024 FSM states IDLE, RUN, DONE; reset enters IDLE.
REQ-025 IDLE->RUN on start; RUN->DONE on qualification or timeout; DONE->IDLE next cycle; start in DONE->RUN.
REQ-026 start in RUN restarts: counters, qualified_mask, timer reloaded in the same cycle.
REQ-027 abort in RUN or DONE -> IDLE, no done pulse; abort wins over simultaneous start.
REQ-028 OS matches when symbol 6 equals 0x4A (TS1) or 0x45 (TS2) per mode and, in modes 1/3, symbol 1 equals latched link_number.
REQ-029 In RUN, per active lane with os_valid: match increments counter saturating at req_count; non-match clears counter to 0.
REQ-030 Lane qualified when counter equals effective req_count; flag is registered, visible in qualified_mask the cycle after the qualifying OS.
REQ-031 Inactive lanes ignore os_valid, counter stays 0, flag stays 0.
REQ-032 Qualification: ALL_LANES=1 all masked lanes flagged; ALL_LANES=0 any masked lane flagged; empty lane_mask qualifies at the first RUN cycle.
REQ-033 Timer loads timeout_cycles at start, decrements each RUN cycle, timeout when it reaches 0 from 1.
REQ-034 Qualification and timeout in same cycle: success=1, timed_out=0.
REQ-035 done asserts one cycle after the qualifying/timeout condition, in the DONE state.
REQ-036 success/timed_out/captured fields hold until next start or abort, which clear success/timed_out.
REQ-037 rate_id, link_number_out, upconfig_cap update on each matching OS of the lowest-index active lane during RUN only.

Reset
REQ-038 Asynchronous assertion of reset=0 forces IDLE, all counters, timer, and every output to 0 immediately, including mid-RUN.
REQ-039 Release is synchronised externally; first active edge after release is a normal IDLE cycle.

Structure
REQ-040 Shared package rx_ltssm_pkg holds TS1_ID 0x4A, TS2_ID 0x45, mode encodings, FSM state enum, symbol index constants (LINK_SYM=1, RATE_SYM=4, ID_SYM=6).
REQ-041 One sub-module rx_os_lane_checker per lane (generate loop): match decode, consecutive counter, qualified flag.
REQ-042 Top holds FSM, timer, qualification reduction, capture registers.

Verification
REQ-043 NUM_LANES=4, mode 0, req_count 8, mask 0xF, 8 TS1 on all lanes -> done with success=1, qualified_mask=0xF, timed_out=0.
REQ-044 Mode 3, link_number 0x05, lane 2 sends 4 TS2 link 0x05, one TS2 link 0x07, 8 TS2 link 0x05 -> lane 2 counter resets at mismatch, qualifies after the second run's 8th OS.
REQ-045 timeout_cycles 100, no valid OS -> done at cycle 101 after start, timed_out=1, success=0.
REQ-046 Last qualifying OS lands in the cycle the timer hits 0 -> success=1, timed_out=0.
REQ-047 reset=0 mid-RUN with counters at 5 -> all outputs 0 at once; after release, start and 8 OS -> normal success.
REQ-048 ALL_LANES=0, mask 0x3, only lane 1 sends 8 TS1 rate_id 0x42 -> success=1, rate_id=0x42, upconfig_cap=1, qualified_mask=0x2.
